pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_ctrl_stall_wdog.sv | 51 +++++
 rtl/pipe_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU pipeline definitions: stall-vector encodings, multi-cycle FSM
// states and the EX length clamp helper.
package pipe_ctrl_pkg;

  // stall bit order: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

  function automatic logic [5:0] clamp_len(input logic [5:0] len,
                                           input logic [5:0] max_len);
    logic [5:0] res;
    if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall watchdog: saturating count of consecutive stalled cycles and a
// sticky hang flag that rises in the cycle the count reaches WDOG.
module stall_wdog #(
  parameter int WDOG = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_active,
  output logic hang
);

  localparam int CW = $clog2(WDOG + 1);
  localparam logic [CW:0] WDOG_W = (CW + 1)'(WDOG);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic [CW:0]   cnt_inc_s;
  logic          hang_r;
  logic          reach_s;

  // Next count: increment while stalled, saturate at WDOG, clear otherwise.
  always_comb begin
    cnt_inc_s = {1'b0, cnt_r} + {{CW{1'b0}}, 1'b1};
    reach_s   = 1'b0;
    cnt_nxt_s = cnt_r;
    if (stall_active) begin
      if (cnt_inc_s >= WDOG_W) begin
        reach_s   = 1'b1;
        cnt_nxt_s = WDOG_W[CW-1:0];
      end else begin
        cnt_nxt_s = cnt_inc_s[CW-1:0];
      end
    end else begin
      cnt_nxt_s = {CW{1'b0}};
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {CW{1'b0}};
      hang_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      hang_r <= hang_r | reach_s;
    end
  end

  assign hang = hang_r | reach_s;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritised stall vector, multi-cycle EX
// sequencing, deferred branch flush and a stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_MAX = 32,
  parameter int WDOG   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        ex_mc_start,
  input  logic [5:0]  ex_mc_len,
  input  logic        stallreq_mem,
  input  logic        flush_req,
  input  logic [31:0] flush_target,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        ex_mc_done,
  output logic        hang
);

  localparam logic [5:0] MC_MAX_L = 6'(MC_MAX);

  mc_state_e   state_r;
  mc_state_e   state_nxt_s;
  logic [5:0]  mc_cnt_r;
  logic [5:0]  mc_cnt_nxt_s;
  logic [5:0]  len_eff_s;
  logic        mc_start_s;
  logic        mc_active_s;
  logic        mc_last_s;
  logic        done_r;

  logic        flush_block_s;
  logic        flush_s;
  logic [31:0] tgt_sel_s;
  logic        pend_r;
  logic        pend_nxt_s;
  logic [31:0] pend_tgt_r;
  logic [31:0] pend_tgt_nxt_s;
  logic [31:0] new_pc_r;

  logic [5:0]  stall_s;
  logic        stall_act_s;
  logic        hang_s;

  // Flush arbitration: a flush can only leave while MEM is moving and EX is
  // not mid multi-cycle; otherwise the target waits in the pending register.
  always_comb begin
    flush_block_s  = stallreq_mem | (state_r == MC_BUSY);
    flush_s        = (flush_req | pend_r) & ~flush_block_s & ~rst;
    tgt_sel_s      = flush_req ? flush_target : pend_tgt_r;
    pend_nxt_s     = pend_r;
    pend_tgt_nxt_s = pend_tgt_r;
    if (flush_s) begin
      pend_nxt_s = 1'b0;
    end else if (flush_req) begin
      pend_nxt_s     = 1'b1;
      pend_tgt_nxt_s = flush_target;
    end else begin
      pend_nxt_s     = pend_r;
      pend_tgt_nxt_s = pend_tgt_r;
    end
  end

  // A branch flushing in this very cycle kills the EX op, so it cannot start.
  always_comb begin
    len_eff_s  = clamp_len(ex_mc_len, MC_MAX_L);
    mc_start_s = (state_r == IDLE) & ex_mc_start & (len_eff_s >= 6'd2) & ~flush_s;
    mc_last_s  = (state_r == MC_BUSY) & ~stallreq_mem & (mc_cnt_r <= 6'd1);
    mc_active_s = (state_r == MC_BUSY) | mc_start_s;
  end

  // Multi-cycle FSM next state; the start cycle is already stall cycle 1.
  always_comb begin
    state_nxt_s  = state_r;
    mc_cnt_nxt_s = mc_cnt_r;
    case (state_r)
      IDLE: begin
        if (mc_start_s) begin
          state_nxt_s  = MC_BUSY;
          mc_cnt_nxt_s = len_eff_s - 6'd1;
        end else begin
          state_nxt_s  = IDLE;
          mc_cnt_nxt_s = mc_cnt_r;
        end
      end
      MC_BUSY: begin
        if (stallreq_mem) begin
          state_nxt_s  = MC_BUSY;
          mc_cnt_nxt_s = mc_cnt_r;
        end else if (mc_cnt_r <= 6'd1) begin
          state_nxt_s  = IDLE;
          mc_cnt_nxt_s = 6'd0;
        end else begin
          state_nxt_s  = MC_BUSY;
          mc_cnt_nxt_s = mc_cnt_r - 6'd1;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        mc_cnt_nxt_s = 6'd0;
      end
    endcase
  end

  // Stall vector by priority; a flush cycle releases every stage.
  always_comb begin
    stall_s = STALL_NONE;
    if (rst) begin
      stall_s = STALL_NONE;
    end else if (flush_s) begin
      stall_s = STALL_NONE;
    end else if (stallreq_mem) begin
      stall_s = STALL_MEM;
    end else if (mc_active_s) begin
      stall_s = STALL_EX;
    end else if (stallreq_id) begin
      stall_s = STALL_ID;
    end else if (stallreq_if) begin
      stall_s = STALL_IF;
    end else begin
      stall_s = STALL_NONE;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      mc_cnt_r   <= 6'd0;
      done_r     <= 1'b0;
      pend_r     <= 1'b0;
      pend_tgt_r <= 32'd0;
      new_pc_r   <= 32'd0;
    end else begin
      state_r    <= state_nxt_s;
      mc_cnt_r   <= mc_cnt_nxt_s;
      done_r     <= mc_last_s;
      pend_r     <= pend_nxt_s;
      pend_tgt_r <= pend_tgt_nxt_s;
      new_pc_r   <= flush_s ? tgt_sel_s : new_pc_r;
    end
  end

  assign stall_act_s = |stall_s;

  stall_wdog #(
    .WDOG(WDOG)
  ) u_wdog (
    .clk          (clk),
    .rst          (rst),
    .stall_active (stall_act_s),
    .hang         (hang_s)
  );

  assign stall      = stall_s;
  assign flush      = flush_s;
  assign new_pc     = rst ? 32'd0 : (flush_s ? tgt_sel_s : new_pc_r);
  assign ex_mc_done = done_r & ~rst;
  assign hang       = hang_s & ~rst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_pipe_ctrl;

  localparam logic [5:0] S0   = 6'b000000;
  localparam logic [5:0] SIF  = 6'b000011;
  localparam logic [5:0] SID  = 6'b000111;
  localparam logic [5:0] SEX  = 6'b001111;
  localparam logic [5:0] SMEM = 6'b011111;

  logic        clk;
  logic        rst;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_len;
  logic        stallreq_mem;
  logic        flush_req;
  logic [31:0] flush_target;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_mc_done;
  logic        hang;

  typedef struct {
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    logic        dn;
    logic        hg;
    logic        hchk;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic end_req  = 1'b0;

  pipe_ctrl #(.MC_MAX(32), .WDOG(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_len    (ex_mc_len),
    .stallreq_mem (stallreq_mem),
    .flush_req    (flush_req),
    .flush_target (flush_target),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .ex_mc_done   (ex_mc_done),
    .hang         (hang)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every cycle's outputs are compared against the oldest expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (stall !== e.st || flush !== e.fl || new_pc !== e.pc ||
          ex_mc_done !== e.dn || (e.hchk && hang !== e.hg)) begin
        n_fail++;
        $display("FAIL %s: got stall=%b flush=%b new_pc=%h done=%b hang=%b, want stall=%b flush=%b new_pc=%h done=%b hang=%b(chk=%b)",
                 e.nm, stall, flush, new_pc, ex_mc_done, hang,
                 e.st, e.fl, e.pc, e.dn, e.hg, e.hchk);
      end
    end else if (end_req) begin
      n_checks++;
    end
  end

  task automatic step(input logic r, input logic sif, input logic sid,
                      input logic mcs, input logic [5:0] len, input logic mem,
                      input logic fr, input logic [31:0] ft,
                      input logic [5:0] es, input logic ef, input logic [31:0] ep,
                      input logic ed, input logic eh, input logic hc,
                      input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; stallreq_if = sif; stallreq_id = sid; ex_mc_start = mcs;
    ex_mc_len = len; stallreq_mem = mem; flush_req = fr; flush_target = ft;
    x.st = es; x.fl = ef; x.pc = ep; x.dn = ed; x.hg = eh; x.hchk = hc; x.nm = nm;
    sb_q.push_back(x);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 6'd9, 1'b1, 1'b1, 32'hdead_beef,
         S0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "reset_outputs");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0,
         S0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "post_reset_idle");
  endtask

  task automatic quiet(input logic [5:0] es, input logic [31:0] ep, input logic ed,
                       input logic eh, input logic hc, input string nm);
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, es, 1'b0, ep, ed, eh, hc, nm);
  endtask

  initial begin
    rst = 1'b1; stallreq_if = 1'b0; stallreq_id = 1'b0; ex_mc_start = 1'b0;
    ex_mc_len = 6'd0; stallreq_mem = 1'b0; flush_req = 1'b0; flush_target = 32'd0;

    do_reset();

    // Single-cycle requests and priority
    step(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, SID, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "id_stall");
    quiet(S0, 32'd0, 1'b0, 1'b0, 1'b1, "id_released");
    step(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, SIF, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "if_stall");
    step(1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, SID, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "id_over_if");
    step(1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 32'd0, SMEM, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "mem_over_id");
    quiet(S0, 32'd0, 1'b0, 1'b0, 1'b1, "prio_released");

    // len=0 and len=1 behave as single-cycle ops
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 32'd0, S0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "len1_nostall");
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'd0, S0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "len0_nostall_len1_nodone");
    quiet(S0, 32'd0, 1'b0, 1'b0, 1'b1, "len0_nodone");

    // len=5: five EX stall cycles, a start in MC_BUSY is ignored, done in cycle 6
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 32'd0, SEX, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "mc5_c1");
    quiet(SEX, 32'd0, 1'b0, 1'b0, 1'b1, "mc5_c2");
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd20, 1'b0, 1'b0, 32'd0, SEX, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "mc5_c3_start_ignored");
    quiet(SEX, 32'd0, 1'b0, 1'b0, 1'b1, "mc5_c4");
    quiet(SEX, 32'd0, 1'b0, 1'b0, 1'b1, "mc5_c5");
    quiet(S0, 32'd0, 1'b1, 1'b0, 1'b1, "mc5_c6_done");
    quiet(S0, 32'd0, 1'b0, 1'b0, 1'b1, "mc5_c7_done_pulse");

    // len=5 with two MEM stall cycles mid-op: seven stalled cycles
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 32'd0, SEX, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "mcm_c1");
    quiet(SEX, 32'd0, 1'b0, 1'b0, 1'b1, "mcm_c2");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'd0, SMEM, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "mcm_c3_mem");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'd0, SMEM, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "mcm_c4_mem");
    quiet(SEX, 32'd0, 1'b0, 1'b0, 1'b1, "mcm_c5");
    quiet(SEX, 32'd0, 1'b0, 1'b0, 1'b1, "mcm_c6");
    quiet(SEX, 32'd0, 1'b0, 1'b0, 1'b1, "mcm_c7");
    quiet(S0, 32'd0, 1'b1, 1'b0, 1'b1, "mcm_c8_done");
    quiet(S0, 32'd0, 1'b0, 1'b0, 1'b1, "mcm_c9");

    // Length above MC_MAX clamps to 32 stall cycles
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd40, 1'b0, 1'b0, 32'd0, SEX, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "clamp_c1");
    for (int i = 2; i <= 32; i++) quiet(SEX, 32'd0, 1'b0, 1'b1, 1'b0, "clamp_busy");
    quiet(S0, 32'd0, 1'b1, 1'b1, 1'b0, "clamp_done");

    // Flush deferred by three MEM cycles
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 32'h0000_1040, SMEM, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "fl_mem1");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'd0, SMEM, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "fl_mem2");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'd0, SMEM, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "fl_mem3");
    quiet(S0, 32'h0000_1040, 1'b0, 1'b0, 1'b1, "fl_pending_issue");
    e.fl = 1'b0;
    sb_q[sb_q.size()-1].fl = 1'b1;
    quiet(S0, 32'h0000_1040, 1'b0, 1'b0, 1'b1, "fl_pc_hold");

    // Immediate flush overrides an ID stall
    step(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 32'h0000_2000, S0, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b1, "fl_immediate");
    quiet(S0, 32'h0000_2000, 1'b0, 1'b0, 1'b1, "fl_imm_hold");

    // Flushes during MC_BUSY: last target wins, issued with done
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 32'd0, SEX, 1'b0, 32'h0000_2000, 1'b0, 1'b0, 1'b1, "fl_mc_c1");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 32'h0000_3000, SEX, 1'b0, 32'h0000_2000, 1'b0, 1'b0, 1'b1, "fl_mc_c2");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 32'h0000_3004, SEX, 1'b0, 32'h0000_2000, 1'b0, 1'b0, 1'b1, "fl_mc_c3");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, S0, 1'b1, 32'h0000_3004, 1'b1, 1'b0, 1'b1, "fl_mc_last_wins");
    quiet(S0, 32'h0000_3004, 1'b0, 1'b0, 1'b1, "fl_mc_after");

    // Reset in cycle 2 of a len=10 op with a pending flush: both abandoned
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 1'b1, 1'b1, 32'h0000_4000, SMEM, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "rst_mc_c1");
    step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, S0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "rst_mc_c2_rst");
    for (int i = 0; i < 12; i++) quiet(S0, 32'd0, 1'b0, 1'b0, 1'b1, "rst_abandoned");

    // Watchdog: hang on the 8th consecutive IF stall, sticky afterwards
    do_reset();
    for (int i = 1; i <= 10; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, SIF, 1'b0, 32'd0, 1'b0,
           (i >= 8) ? 1'b1 : 1'b0, 1'b1, "wdog_count");
    for (int i = 0; i < 3; i++) quiet(S0, 32'd0, 1'b0, 1'b1, 1'b1, "wdog_sticky");
    do_reset();

    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
      $fatal(1, "scoreboard did not drain");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
